// File: rtl/enc_pkg.sv
// Shared constants, FSM state type and onehot/index helpers for the event encoder.
package enc_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned CODE_W  = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [CODE_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  // Assumes at most one bit set; an all-zero vector maps to index 0.
  function automatic logic [CODE_W-1:0] onehot2idx(input logic [NUM_REQ-1:0] oh);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) r = r | CODE_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_sel.sv
// Combinational rotating priority selector: lowest set bit at or after 'start', wrapping.
module prio_sel
  import enc_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  input  logic [CODE_W-1:0]  start,
  output logic               any,
  output logic [CODE_W-1:0]  idx
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] low;

  always_comb begin
    // Rotate so that bit 'start' lands at position 0, then isolate the lowest set bit.
    rot = NUM_REQ'({vec, vec} >> start);
    low = rot & (~rot + NUM_REQ'(1));
    any = |vec;
    idx = start + onehot2idx(low);
  end

endmodule

// File: rtl/event_encoder.sv
// Captures multi-hot event lines into a pending vector and presents them one code at a time.
// Build option: define ENC_ROUND_ROBIN_EN for round-robin arbitration (fixed lowest-index priority otherwise).
module event_encoder
  import enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ready,
  output logic [CODE_W-1:0]  code,
  output logic               valid,
  output logic [NUM_REQ-1:0] pending,
  output logic               overflow
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               valid_q, valid_d;
  logic               overflow_q, overflow_d;

  logic               xfer;
  logic [NUM_REQ-1:0] clr;
  logic [NUM_REQ-1:0] cap;
  logic [NUM_REQ-1:0] sel_vec;
  logic [CODE_W-1:0]  sel_start;
  logic               sel_any;
  logic [CODE_W-1:0]  sel_idx;

`ifdef ENC_ROUND_ROBIN_EN
  logic [CODE_W-1:0]  last_q, last_d;

  always_comb begin
    last_d    = xfer ? code_q : last_q;
    sel_start = last_q + CODE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= CODE_W'(NUM_REQ - 1);
    else        last_q <= last_d;
  end
`else
  assign sel_start = '0;
`endif

  // Pending bookkeeping; a same-cycle clear and re-request keeps the bit as a fresh event.
  always_comb begin
    xfer       = valid_q && ready;
    clr        = xfer ? idx2onehot(code_q) : '0;
    cap        = en ? req : '0;
    pending_d  = (pending_q & ~clr) | cap;
    overflow_d = |(cap & pending_q & ~clr);
    sel_vec    = pending_q & ~clr;
  end

  prio_sel u_prio_sel (
    .vec   (sel_vec),
    .start (sel_start),
    .any   (sel_any),
    .idx   (sel_idx)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (sel_any) begin
          code_d  = sel_idx;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (xfer) begin
          if (sel_any) begin
            code_d = sel_idx;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign code     = code_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_event_encoder.sv
// Directed scoreboard bench for event_encoder; expected codes queued at stimulus time.
module tb_event_encoder;
  import enc_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic [NUM_REQ-1:0] req;
  logic               ready;
  logic [CODE_W-1:0]  code;
  logic               valid;
  logic [NUM_REQ-1:0] pending;
  logic               overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [CODE_W-1:0] exp_q[$];

  event_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .ready    (ready),
    .code     (code),
    .valid    (valid),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the transfer about to happen at the next edge against the scoreboard, then advances.
  task automatic tick();
    logic [CODE_W-1:0] e;
    if (valid === 1'b1 && ready === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected observed=%0h expected=none", code);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        assert (code === e) else begin
          n_err++;
          $error("FAIL sb_code observed=%0h expected=%0h", code, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = '0;
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending", 32'(pending), 32'h00);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_code", 32'(code), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;

    // Single event, two-cycle latency, one-cycle valid
    en = 1'b1; req = 8'h04; ready = 1'b1;
    exp_q.push_back(3'd2);
    tick();
    req = '0;
    chk("lat_pending", 32'(pending), 32'h04);
    chk("lat_valid0", 32'(valid), 32'h0);
    tick();
    chk("lat_valid1", 32'(valid), 32'h1);
    chk("lat_code", 32'(code), 32'h2);
    tick();
    chk("lat_valid_drop", 32'(valid), 32'h0);
    chk("lat_pending_clr", 32'(pending), 32'h00);

    // Multi-hot burst drains back-to-back while en is low
    req = 8'hA5;
    if (1) begin
`ifdef ENC_ROUND_ROBIN_EN
      // last = 2 after previous transfer: search begins at 3
      exp_q.push_back(3'd5); exp_q.push_back(3'd7);
      exp_q.push_back(3'd0); exp_q.push_back(3'd2);
`else
      exp_q.push_back(3'd0); exp_q.push_back(3'd2);
      exp_q.push_back(3'd5); exp_q.push_back(3'd7);
`endif
    end
    tick();
    req = '0; en = 1'b0;
    chk("burst_pending", 32'(pending), 32'hA5);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("burst_valid", 32'(valid), 32'h1);
    end
    tick();
    chk("burst_done", 32'(valid), 32'h0);
    chk("burst_pending0", 32'(pending), 32'h00);
    en = 1'b1;

    // Backpressure holds code and valid stable
    req = 8'h08; ready = 1'b0;
    exp_q.push_back(3'd3);
    tick();
    req = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(valid), 32'h1);
      chk("hold_code", 32'(code), 32'h3);
      tick();
    end
    ready = 1'b1;
    tick();
    chk("hold_release_valid", 32'(valid), 32'h0);
    chk("hold_release_pend", 32'(pending), 32'h00);
    tick();
    chk("hold_single", 32'(valid), 32'h0);

    // Re-request of an already pending bit is merged and flagged
    req = 8'h10; ready = 1'b0;
    exp_q.push_back(3'd4);
    tick();
    chk("ovf_none_first", 32'(overflow), 32'h0);
    tick();
    req = '0;
    chk("ovf_pulse", 32'(overflow), 32'h1);
    tick();
    chk("ovf_one_cycle", 32'(overflow), 32'h0);
    chk("ovf_code", 32'(code), 32'h4);
    ready = 1'b1;
    tick();
    chk("ovf_drain_valid", 32'(valid), 32'h0);
    chk("ovf_drain_pend", 32'(pending), 32'h00);
    tick();

    // Re-request on the clearing cycle is a new event, not an overflow
    req = 8'h02; ready = 1'b0;
    exp_q.push_back(3'd1);
    tick();
    req = '0;
    tick();
    chk("reclr_code", 32'(code), 32'h1);
    ready = 1'b1; req = 8'h02;
    exp_q.push_back(3'd1);
    tick();
    req = '0;
    chk("reclr_no_ovf", 32'(overflow), 32'h0);
    chk("reclr_pending", 32'(pending), 32'h02);
    chk("reclr_valid", 32'(valid), 32'h0);
    tick();
    chk("reclr_valid2", 32'(valid), 32'h1);
    tick();
    chk("reclr_done", 32'(valid), 32'h0);

    // en low blocks captures
    en = 1'b0; req = 8'hFF;
    tick();
    tick();
    chk("en0_pending", 32'(pending), 32'h00);
    chk("en0_valid", 32'(valid), 32'h0);

    // Asynchronous reset in the middle of a drain
    en = 1'b1;
    if (1) begin
`ifdef ENC_ROUND_ROBIN_EN
      // last = 1: order 2,3,...,7,0,1
      for (int i = 2; i < 10; i++) exp_q.push_back(CODE_W'(i));
`else
      for (int i = 0; i < 8; i++) exp_q.push_back(CODE_W'(i));
`endif
    end
    tick();
    req = '0;
    tick();
    tick();
    tick();
    chk("drain_mid_valid", 32'(valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'h0);
    chk("arst_pending", 32'(pending), 32'h00);
    chk("arst_code", 32'(code), 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Arbitration policy after reset: last = 0, then two simultaneous events
    req = 8'h01;
    exp_q.push_back(3'd0);
    tick();
    req = '0;
    tick();
    tick();
    req = 8'h03;
`ifdef ENC_ROUND_ROBIN_EN
    exp_q.push_back(3'd1); exp_q.push_back(3'd0);
`else
    exp_q.push_back(3'd0); exp_q.push_back(3'd1);
`endif
    tick();
    req = '0;
    tick();
`ifdef ENC_ROUND_ROBIN_EN
    chk("rr_first", 32'(code), 32'h1);
`else
    chk("rr_first", 32'(code), 32'h0);
`endif
    tick();
    tick();
    chk("rr_done", 32'(valid), 32'h0);

    chk("sb_left", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/event_encoder.md
EVENT_ENCODER -- requirements
Module: event_encoder

Interface
REQ-001 The block SHALL have no parameters; the request width SHALL be fixed at 8 and the code width at 3.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  request capture enable; when 0, req is ignored.
REQ-005 req  input  8  event lines, multi-hot allowed, sampled every cycle.
REQ-006 code  output  3  registered binary index of the event being presented.
REQ-007 valid  output  1  registered; code is meaningful when 1.
REQ-008 ready  input  1  consumer accepts code; a transfer SHALL occur on any cycle with valid && ready.
REQ-009 pending  output  8  registered pending-event vector, including the bit currently presented.
REQ-010 overflow  output  1  registered one-cycle pulse on a lost (merged) event.

Function
REQ-011 The pending register SHALL update as pending_next = (pending & ~clr) | (en ? req : 0).
- clr SHALL be onehot(code) on a transfer cycle, and 0 otherwise.
REQ-012 When req[i] and clr[i] are both set in the same cycle, bit i SHALL remain set, and the event SHALL be counted as new (no overflow).
REQ-013 overflow SHALL pulse for one cycle, on the edge after the cause, when en && req[i] && pending[i] && !clr[i] holds for any i.
REQ-014 The state machine SHALL have two states, IDLE and PRESENT.
- In IDLE with pending != 0, the block SHALL load code with the selected index, set valid and enter PRESENT.
REQ-015 In PRESENT with !ready, code and valid SHALL hold stable.
REQ-016 In PRESENT on a transfer, the block SHALL select from (pending & ~clr) for the next cycle:
- if that vector is nonzero, it SHALL load the new code and stay in PRESENT;
- otherwise it SHALL clear valid and return to IDLE.
REQ-017 Latency SHALL be 2 cycles: a req sampled at edge N sets pending after edge N, and valid rises after edge N+1.
REQ-018 Throughput SHALL be one code per cycle while ready is held at 1.
REQ-019 Default selection SHALL be fixed priority, with the lowest index highest (bit 0 maps to code 3'd0).
REQ-020 en = 0 SHALL block only new captures; already-pending events SHALL continue to drain normally.

Reset
REQ-021 While rst_n = 0, the block SHALL immediately force the following values, independent of clk, including mid-drain:
- pending = 8'h00, code = 3'd0, valid = 0, overflow = 0;
- state = IDLE;
- round-robin last pointer = 3'd7.
REQ-022 After rst_n deasserts, the first capture SHALL occur on the next rising edge.

Configuration
REQ-023 Macro ENC_ROUND_ROBIN_EN SHALL select the arbitration policy.
- Defined: the search SHALL start at (last + 1) mod 8, wrapping 7 -> 0, where last updates to code on each transfer.
- Undefined: the block SHALL use the fixed priority of REQ-019, with no pointer register present.

Structure
REQ-024 Package enc_pkg SHALL hold:
- constants NUM_REQ = 8 and CODE_W = 3;
- the state enum (IDLE, PRESENT);
- the onehot/index conversion functions.
REQ-025 Selection SHALL be a combinational sub-module prio_sel.
- Inputs: vec[7:0] and start[2:0].
- Outputs: any and idx[2:0].
- The fixed-priority build SHALL tie start to 0.

Verification
REQ-026 req = 8'h04 for one cycle, ready = 1 -> valid is high for exactly one cycle, 2 cycles after the req cycle, with code = 2; pending returns to 0.
REQ-027 req = 8'hA5 for one cycle, ready = 1 (fixed priority) -> codes 0, 2, 5, 7 on consecutive cycles, then valid = 0.
REQ-028 Code 3 presented, ready = 0 for 5 cycles -> code and valid stable; then ready = 1 -> exactly one transfer and pending[3] cleared.
REQ-029 With pending[4] = 1 and not transferring, req = 8'h10 -> one overflow pulse, and only one code 4 emitted.
REQ-030 en = 0 with req = 8'hFF -> pending and valid stay 0; rst_n low during a drain of 8'hFF -> valid = 0 and pending = 0 asynchronously.
REQ-031 Round-robin check: after reset, req = 8'h01 and transfer (last = 0), then req = 8'h03.
- With ENC_ROUND_ROBIN_EN: codes 1 then 0.
- Without ENC_ROUND_ROBIN_EN: codes 0 then 1.
